// File: rtl/sram_ext_port_arbiter.sv
// sram_ext_port_arbiter: round-robin, burst-locking arbiter that shares
// the SRAM external port between two requesters and routes read returns.
module sram_ext_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              last0,
  input  logic              last1,
  input  logic [63:0]       addr0,
  input  logic [63:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic [63:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic [RD_LAT-1:0] tv_q;
  logic [RD_LAT-1:0] tid_q;

  // Grant decode; held low while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!arst) begin
      unique case (state_q)
        IDLE: begin
          if (req0 && (!req1 || !prio_q)) gnt0 = 1'b1;
          else if (req1)                  gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = req0;
        LOCK1:   gnt1 = req1;
        default: ;
      endcase
    end
  end

  // Lock / priority update on each granted beat
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (gnt0) begin
      if (last0) begin
        state_d = IDLE;
        prio_d  = 1'b1;
      end else begin
        state_d = LOCK0;
      end
    end else if (gnt1) begin
      if (last1) begin
        state_d = IDLE;
        prio_d  = 1'b0;
      end else begin
        state_d = LOCK1;
      end
    end
  end

  // SRAM drive: granted beat passes through, otherwise last value is held
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt0) begin
      addr_d  = addr0;
      wdata_d = wdata0;
    end else if (gnt1) begin
      addr_d  = addr1;
      wdata_d = wdata1;
    end
  end

  assign addr_ext  = addr_d;
  assign wdata_ext = wdata_d;
  assign wen_ext   = (gnt0 & we0) | (gnt1 & we1);
  assign ren_ext   = (gnt0 & ~we0) | (gnt1 & ~we1);

  assign rvalid0 = tv_q[RD_LAT-1] & ~tid_q[RD_LAT-1];
  assign rvalid1 = tv_q[RD_LAT-1] & tid_q[RD_LAT-1];
  assign rdata0  = rvalid0 ? rdata_ext : rd0_q;
  assign rdata1  = rvalid1 ? rdata_ext : rd1_q;
  assign busy    = (state_q != IDLE) | (|tv_q);

  // Arbiter state and held SRAM drive values
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read tag pipeline aligned to SRAM latency, plus held read data
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tv_q  <= '0;
      tid_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      tv_q[0]  <= ren_ext;
      tid_q[0] <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
      rd0_q <= rdata0;
      rd1_q <= rdata1;
    end
  end

endmodule
